// File: rtl/fifo_xfer_ctrl_if.sv
// Handshake and status bundle between the transfer controller and its
// surroundings: source FIFO read side, destination FIFO write side,
// command inputs and status outputs.
interface fifo_xfer_ctrl_if #(
    parameter int DATA_W = 128,
    parameter int LEN_W  = 16
);
    logic              start;
    logic [LEN_W-1:0]  xfer_len;
    logic              abort;
    logic              in_empty;
    logic              in_rd_en;
    logic [DATA_W-1:0] in_dout;
    logic              in_valid;
    logic              out_full;
    logic              out_wr_en;
    logic [DATA_W-1:0] out_din;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [LEN_W-1:0]  words_done;
    logic              seq_err;

    // Controller side
    modport master (
        input  start, xfer_len, abort, in_empty, in_dout, in_valid, out_full,
        output in_rd_en, out_wr_en, out_din, busy, done, aborted, words_done, seq_err
    );

    // Environment side (FIFOs, command/status endpoints)
    modport slave (
        output start, xfer_len, abort, in_empty, in_dout, in_valid, out_full,
        input  in_rd_en, out_wr_en, out_din, busy, done, aborted, words_done, seq_err
    );
endinterface

// File: rtl/fifo_xfer_ctrl.sv
// Block transfer sequencer: reads xfer_len words from the source FIFO and
// writes them in order to the destination FIFO. A small skid buffer holds
// words already requested from the source while the destination is full,
// so reads are only issued when a slot is guaranteed.
module fifo_xfer_ctrl #(
    parameter int DATA_W     = 128,
    parameter int LEN_W      = 16,
    parameter int SKID_DEPTH = 4
) (
    input  logic             sys_clk,
    input  logic             rst,
    fifo_xfer_ctrl_if.master bus
);
    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] SKID_LIM = (CNT_W + 1)'(SKID_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_issued;
    logic [LEN_W-1:0]  r_words_done;
    logic              r_pending;
    logic              r_aborted;
    logic              r_seq_err;
    logic [DATA_W-1:0] r_skid_mem [SKID_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_skid_cnt;
    logic [CNT_W-1:0]  w_skid_cnt_next;
    logic [CNT_W:0]    w_occ;
    logic [LEN_W-1:0]  w_words_next;
    logic              w_active;
    logic              w_abort_act;
    logic              w_start_acc;
    logic              w_skid_empty;
    logic              w_rd_en;
    logic              w_wr_en;
    logic              w_push;

    assign w_active     = (r_state == S_RUN) || (r_state == S_DRAIN);
    // Abort is live from the cycle it is seen until the transfer closes.
    assign w_abort_act  = w_active && (bus.abort || r_aborted);
    assign w_start_acc  = (r_state == S_IDLE) && bus.start;
    assign w_skid_empty = (r_skid_cnt == '0);
    // Slots already committed: words buffered plus the read still in flight.
    assign w_occ        = {1'b0, r_skid_cnt} + {{CNT_W{1'b0}}, r_pending};

    assign w_rd_en = (r_state == S_RUN) && !w_abort_act && !bus.in_empty &&
                     (r_issued < r_len) && (w_occ < SKID_LIM);
    assign w_wr_en = !w_skid_empty && !bus.out_full && !w_abort_act;
    // Words arriving during an abort, or without a matching read, are dropped.
    assign w_push  = bus.in_valid && r_pending && !w_abort_act;
    assign w_words_next = w_wr_en ? r_words_done + LEN_W'(1) : r_words_done;

    assign bus.in_rd_en   = w_rd_en;
    assign bus.out_wr_en  = w_wr_en;
    assign bus.out_din    = w_skid_empty ? '0 : r_skid_mem[r_rd_ptr];
    assign bus.busy       = w_active;
    assign bus.done       = (r_state == S_DONE);
    assign bus.aborted    = r_aborted;
    assign bus.words_done = r_words_done;
    assign bus.seq_err    = r_seq_err;

    // Skid occupancy after this cycle's push/pop/flush
    always_comb begin
        w_skid_cnt_next = r_skid_cnt;
        if (w_abort_act) begin
            w_skid_cnt_next = '0;
        end else if (w_push && !w_wr_en) begin
            w_skid_cnt_next = r_skid_cnt + CNT_W'(1);
        end else if (!w_push && w_wr_en) begin
            w_skid_cnt_next = r_skid_cnt - CNT_W'(1);
        end
    end

    // Next-state logic; DRAIN closes on the cycle its last word is written
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = (bus.xfer_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_abort_act) begin
                    if (!r_pending) w_state_next = S_DONE;
                end else if (w_rd_en && (r_issued + LEN_W'(1) == r_len)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_abort_act) begin
                    if (!r_pending) w_state_next = S_DONE;
                end else if (!r_pending && (w_skid_cnt_next == '0) &&
                             (w_words_next == r_len)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Transfer bookkeeping: length, issue/write counters, abort and error flags
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_len        <= '0;
            r_issued     <= '0;
            r_words_done <= '0;
            r_pending    <= 1'b0;
            r_aborted    <= 1'b0;
            r_seq_err    <= 1'b0;
        end else begin
            r_pending <= w_rd_en;
            if (w_start_acc) begin
                r_len        <= bus.xfer_len;
                r_issued     <= '0;
                r_words_done <= '0;
                r_aborted    <= 1'b0;
                r_seq_err    <= 1'b0;
            end else begin
                if (w_rd_en) r_issued <= r_issued + LEN_W'(1);
                r_words_done <= w_words_next;
                if (w_active && bus.abort) r_aborted <= 1'b1;
                if (bus.in_valid && !r_pending) r_seq_err <= 1'b1;
            end
        end
    end

    // Skid pointers and count; an abort empties the buffer at once
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_skid_cnt <= '0;
        end else begin
            r_skid_cnt <= w_skid_cnt_next;
            if (w_abort_act) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_wr_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Skid storage; contents are don't-care until the count covers them
    always_ff @(posedge sys_clk) begin
        if (w_push) r_skid_mem[r_wr_ptr] <= bus.in_dout;
    end
endmodule

// File: tb/tb_fifo_xfer_ctrl.sv
module tb_fifo_xfer_ctrl;
    localparam int DW = 128;
    localparam int LW = 16;
    localparam int SD = 4;
    typedef logic [DW-1:0] word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_xfer_ctrl_if #(.DATA_W(DW), .LEN_W(LW)) bus ();
    fifo_xfer_ctrl #(.DATA_W(DW), .LEN_W(LW), .SKID_DEPTH(SD)) dut (
        .sys_clk (clk),
        .rst     (rst),
        .bus     (bus.master)
    );

    int checks = 0;
    int errors = 0;

    // Environment model: source FIFO contents, words arriving later, and
    // the expected destination stream (the first len words fed in).
    word_t src_q[$], late_q[$], exp_q[$], wr_log[$];
    word_t rd_word;
    logic  rd_now;
    int    cyc, late_cyc, of_lo, of_hi, full_pct, feed_pct;
    logic [63:0] rd_mask, wr_mask, busy_mask;
    int    rd_cnt, wr_cnt, max_out, done_cyc, done_cnt;
    int    viol_empty, viol_full, viol_after_done;

    function automatic word_t rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic clear_log();
        src_q.delete(); late_q.delete(); exp_q.delete(); wr_log.delete();
        rd_mask = '0; wr_mask = '0; busy_mask = '0;
        rd_cnt = 0; wr_cnt = 0; max_out = 0; done_cyc = -1; done_cnt = 0;
        viol_empty = 0; viol_full = 0; viol_after_done = 0;
        late_cyc = -1; of_lo = 1000; of_hi = -1; full_pct = 0; feed_pct = 0;
    endtask

    // One clock: observe the DUT mid-cycle, then drive the next cycle's inputs.
    task automatic step();
        @(negedge clk);
        if (rd_cnt - wr_cnt > max_out) max_out = rd_cnt - wr_cnt;
        rd_now = bus.in_rd_en;
        if (bus.in_rd_en) begin
            rd_cnt++;
            if (src_q.size() == 0) viol_empty++;
            else rd_word = src_q.pop_front();
            if (cyc < 64) rd_mask[cyc] = 1'b1;
        end
        if (bus.out_wr_en) begin
            wr_cnt++;
            wr_log.push_back(bus.out_din);
            if (bus.out_full) viol_full++;
            if (done_cnt > 0) viol_after_done++;
            if (cyc < 64) wr_mask[cyc] = 1'b1;
        end
        if (bus.busy && cyc < 64) busy_mask[cyc] = 1'b1;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == late_cyc) while (late_q.size() > 0) src_q.push_back(late_q.pop_front());
        if (feed_pct > 0 && late_q.size() > 0 && $urandom_range(99) < feed_pct)
            src_q.push_back(late_q.pop_front());
        bus.in_valid = rd_now;
        bus.in_dout  = rd_now ? rd_word : rand_word();
        bus.in_empty = (src_q.size() == 0);
        bus.out_full = (full_pct > 0) ? ($urandom_range(99) < full_pct)
                                      : (cyc >= of_lo && cyc <= of_hi);
    endtask

    task automatic load(input int n, input bit tag);
        word_t w;
        for (int i = 0; i < n; i++) begin
            w = rand_word();
            if (tag) w[7:0] = 8'(i + 1);
            src_q.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    // Start pulse occupies cycle 0
    task automatic begin_xfer(input int len);
        bus.xfer_len = LW'(len);
        bus.in_empty = (src_q.size() == 0);
        bus.out_full = 1'b0;
        bus.start    = 1'b1;
        cyc = 0;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int i = 0; i < budget && done_cnt == 0; i++) step();
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
        end
        $display("xfer %s: words_done=%0d writes=%0d done@%0d aborted=%0b",
                 name, bus.words_done, wr_log.size(), done_cyc, bus.aborted);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks += 8;
        if (bus.in_rd_en !== 1'b0)    begin errors++; $display("FAIL rst_rd_en got %b exp 0", bus.in_rd_en); end
        if (bus.out_wr_en !== 1'b0)   begin errors++; $display("FAIL rst_wr_en got %b exp 0", bus.out_wr_en); end
        if (bus.out_din !== '0)       begin errors++; $display("FAIL rst_out_din got %h exp 0", bus.out_din); end
        if (bus.busy !== 1'b0)        begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        if (bus.done !== 1'b0)        begin errors++; $display("FAIL rst_done got %b exp 0", bus.done); end
        if (bus.aborted !== 1'b0)     begin errors++; $display("FAIL rst_aborted got %b exp 0", bus.aborted); end
        if (bus.words_done !== '0)    begin errors++; $display("FAIL rst_words_done got %0d exp 0", bus.words_done); end
        if (bus.seq_err !== 1'b0)     begin errors++; $display("FAIL rst_seq_err got %b exp 0", bus.seq_err); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        clear_log();
        load(4, 1'b1);
        begin_xfer(4);
        wait_done(40, "basic");
        checks += 6;
        if (rd_mask !== 64'h1E)   begin errors++; $display("FAIL basic_rd_cycles got %h exp 1e", rd_mask); end
        if (wr_mask !== 64'h78)   begin errors++; $display("FAIL basic_wr_cycles got %h exp 78", wr_mask); end
        if (busy_mask !== 64'h7E) begin errors++; $display("FAIL basic_busy_cycles got %h exp 7e", busy_mask); end
        if (done_cyc != 7)        begin errors++; $display("FAIL basic_done_cycle got %0d exp 7", done_cyc); end
        if (bus.words_done !== 16'd4) begin errors++; $display("FAIL basic_words_done got %0d exp 4", bus.words_done); end
        if (bus.aborted !== 1'b0) begin errors++; $display("FAIL basic_aborted got %b exp 0", bus.aborted); end
        checks++;
        if (wr_log.size() != 4) begin errors++; $display("FAIL basic_count got %0d exp 4", wr_log.size()); end
        for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wr_log[i] !== exp_q[i]) begin errors++; $display("FAIL basic_data[%0d] got %h exp %h", i, wr_log[i], exp_q[i]); end
        end
    endtask

    task automatic test_zero_len();
        clear_log();
        load(2, 1'b0);
        begin_xfer(0);
        wait_done(10, "zero_len");
        checks += 5;
        if (rd_mask !== '0)        begin errors++; $display("FAIL zero_rd got %h exp 0", rd_mask); end
        if (wr_mask !== '0)        begin errors++; $display("FAIL zero_wr got %h exp 0", wr_mask); end
        if (done_cyc != 1)         begin errors++; $display("FAIL zero_done_cycle got %0d exp 1", done_cyc); end
        if (bus.words_done !== '0) begin errors++; $display("FAIL zero_words_done got %0d exp 0", bus.words_done); end
        if (bus.aborted !== 1'b0)  begin errors++; $display("FAIL zero_aborted got %b exp 0", bus.aborted); end
        // abort while idle must not flag anything
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        step();
        checks += 2;
        if (bus.aborted !== 1'b0) begin errors++; $display("FAIL idle_abort_flag got %b exp 0", bus.aborted); end
        if (bus.busy !== 1'b0)    begin errors++; $display("FAIL idle_abort_busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_backpressure();
        clear_log();
        load(16, 1'b1);
        of_lo = 5;
        of_hi = 20;
        begin_xfer(16);
        wait_done(120, "backpressure");
        checks += 6;
        if (max_out != SD)      begin errors++; $display("FAIL bp_max_buffered got %0d exp %0d", max_out, SD); end
        if (viol_full != 0)     begin errors++; $display("FAIL bp_write_while_full got %0d exp 0", viol_full); end
        if (viol_empty != 0)    begin errors++; $display("FAIL bp_read_while_empty got %0d exp 0", viol_empty); end
        if (viol_after_done != 0) begin errors++; $display("FAIL bp_write_after_done got %0d exp 0", viol_after_done); end
        if (bus.words_done !== 16'd16) begin errors++; $display("FAIL bp_words_done got %0d exp 16", bus.words_done); end
        if (bus.seq_err !== 1'b0) begin errors++; $display("FAIL bp_seq_err got %b exp 0", bus.seq_err); end
        checks++;
        if (wr_log.size() != 16) begin errors++; $display("FAIL bp_count got %0d exp 16", wr_log.size()); end
        for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wr_log[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d] got %h exp %h", i, wr_log[i], exp_q[i]); end
        end
    endtask

    task automatic test_starve();
        word_t w;
        clear_log();
        load(3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            w = rand_word();
            late_q.push_back(w);
            exp_q.push_back(w);
        end
        late_cyc = 20;
        begin_xfer(8);
        wait_done(80, "starve");
        checks += 4;
        if (rd_mask[19:0] !== 20'hE)  begin errors++; $display("FAIL starve_early_reads got %h exp e", rd_mask[19:0]); end
        if (done_cyc != 27)           begin errors++; $display("FAIL starve_done_cycle got %0d exp 27", done_cyc); end
        if (bus.words_done !== 16'd8) begin errors++; $display("FAIL starve_words_done got %0d exp 8", bus.words_done); end
        if (viol_empty != 0)          begin errors++; $display("FAIL starve_read_while_empty got %0d exp 0", viol_empty); end
        checks++;
        if (wr_log.size() != 8) begin errors++; $display("FAIL starve_count got %0d exp 8", wr_log.size()); end
        for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wr_log[i] !== exp_q[i]) begin errors++; $display("FAIL starve_data[%0d] got %h exp %h", i, wr_log[i], exp_q[i]); end
        end
    endtask

    task automatic test_abort();
        clear_log();
        load(100, 1'b0);
        begin_xfer(100);
        while (cyc < 10) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        wait_done(20, "abort");
        checks += 7;
        if (rd_mask[63:10] !== '0) begin errors++; $display("FAIL abort_rd_after got %h exp 0", rd_mask[63:10]); end
        if (wr_mask[63:10] !== '0) begin errors++; $display("FAIL abort_wr_after got %h exp 0", wr_mask[63:10]); end
        if (done_cyc < 11 || done_cyc > 12) begin errors++; $display("FAIL abort_done_cycle got %0d exp 11..12", done_cyc); end
        if (bus.aborted !== 1'b1) begin errors++; $display("FAIL abort_flag got %b exp 1", bus.aborted); end
        if (wr_log.size() != 7)   begin errors++; $display("FAIL abort_writes got %0d exp 7", wr_log.size()); end
        if (bus.words_done !== LW'(wr_log.size())) begin errors++; $display("FAIL abort_words_done got %0d exp %0d", bus.words_done, wr_log.size()); end
        if (bus.seq_err !== 1'b0) begin errors++; $display("FAIL abort_seq_err got %b exp 0", bus.seq_err); end
        for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wr_log[i] !== exp_q[i]) begin errors++; $display("FAIL abort_data[%0d] got %h exp %h", i, wr_log[i], exp_q[i]); end
        end
    endtask

    task automatic test_seq_err();
        clear_log();
        step();
        bus.in_valid = 1'b1;
        step();
        checks++;
        if (bus.seq_err !== 1'b1) begin errors++; $display("FAIL seq_err_set got %b exp 1", bus.seq_err); end
        repeat (3) step();
        checks++;
        if (bus.seq_err !== 1'b1) begin errors++; $display("FAIL seq_err_sticky got %b exp 1", bus.seq_err); end
        load(2, 1'b0);
        begin_xfer(2);
        checks++;
        if (bus.seq_err !== 1'b0) begin errors++; $display("FAIL seq_err_clear got %b exp 0", bus.seq_err); end
        wait_done(30, "seq_err");
        checks += 2;
        if (bus.words_done !== 16'd2) begin errors++; $display("FAIL seq_words_done got %0d exp 2", bus.words_done); end
        if (wr_log.size() != 2)       begin errors++; $display("FAIL seq_count got %0d exp 2", wr_log.size()); end
        for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wr_log[i] !== exp_q[i]) begin errors++; $display("FAIL seq_data[%0d] got %h exp %h", i, wr_log[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        load(20, 1'b0);
        begin_xfer(20);
        while (cyc < 6) step();
        #2;
        rst = 1'b1;
        #1;
        checks += 5;
        if (bus.in_rd_en !== 1'b0)  begin errors++; $display("FAIL midrst_rd_en got %b exp 0", bus.in_rd_en); end
        if (bus.out_wr_en !== 1'b0) begin errors++; $display("FAIL midrst_wr_en got %b exp 0", bus.out_wr_en); end
        if (bus.busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
        if (bus.words_done !== '0)  begin errors++; $display("FAIL midrst_words_done got %0d exp 0", bus.words_done); end
        if (bus.out_din !== '0)     begin errors++; $display("FAIL midrst_out_din got %h exp 0", bus.out_din); end
        rd_now = 1'b0;
        bus.in_valid = 1'b0;
        src_q.delete();
        bus.in_empty = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        clear_log();
        load(5, 1'b0);
        begin_xfer(5);
        wait_done(30, "after_reset");
        checks += 2;
        if (done_cyc != 8)            begin errors++; $display("FAIL postrst_done_cycle got %0d exp 8", done_cyc); end
        if (bus.words_done !== 16'd5) begin errors++; $display("FAIL postrst_words_done got %0d exp 5", bus.words_done); end
        for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wr_log[i] !== exp_q[i]) begin errors++; $display("FAIL postrst_data[%0d] got %h exp %h", i, wr_log[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int len;
        word_t w;
        for (int it = 0; it < 8; it++) begin
            clear_log();
            len = $urandom_range(24, 1);
            for (int i = 0; i < len; i++) begin
                w = rand_word();
                late_q.push_back(w);
                exp_q.push_back(w);
            end
            feed_pct = $urandom_range(90, 30);
            full_pct = $urandom_range(50, 0);
            begin_xfer(len);
            wait_done(len * 30 + 50, "random");
            checks += 6;
            if (wr_log.size() != len)      begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", it, wr_log.size(), len); end
            if (bus.words_done !== LW'(len)) begin errors++; $display("FAIL rand%0d_words_done got %0d exp %0d", it, bus.words_done, len); end
            if (max_out > SD)              begin errors++; $display("FAIL rand%0d_overfill got %0d exp <=%0d", it, max_out, SD); end
            if (viol_full != 0 || viol_empty != 0) begin errors++; $display("FAIL rand%0d_protocol got full=%0d empty=%0d exp 0", it, viol_full, viol_empty); end
            if (bus.seq_err !== 1'b0)      begin errors++; $display("FAIL rand%0d_seq_err got %b exp 0", it, bus.seq_err); end
            if (bus.aborted !== 1'b0)      begin errors++; $display("FAIL rand%0d_aborted got %b exp 0", it, bus.aborted); end
            for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++) begin
                checks++;
                if (wr_log[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_data[%0d] got %h exp %h", it, i, wr_log[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.xfer_len = '0;
        bus.abort    = 1'b0;
        bus.in_empty = 1'b1;
        bus.in_dout  = '0;
        bus.in_valid = 1'b0;
        bus.out_full = 1'b0;
        rd_now  = 1'b0;
        rd_word = '0;
        cyc     = 0;
        clear_log();
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_starve();
        test_abort();
        test_seq_err();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
